// File: rtl/stopwatch_lap.sv
// BCD stopwatch (h:mm:ss.mmm) with split/lap capture, clocked on the falling edge of NEclk.
// Optional lap FIFO compiled in with `define STOPWATCH_LAP_FIFO_EN.
module stopwatch_lap #(
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned HR_MAX    = 9,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic        NEclk,
    input  logic        Reset,
    input  logic        Start_Stop,
    input  logic        Lap,
    input  logic        Clear,
    output logic [31:0] disp,
    output logic        Running,
    output logic        Frozen,
    output logic        Overflow
`ifdef STOPWATCH_LAP_FIFO_EN
    ,
    input  logic        Lap_pop,
    output logic [31:0] Lap_data,
    output logic        Lap_empty,
    output logic        Lap_full
`endif
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    // Per-digit rollover limits, h in the top nibble.
    localparam logic [31:0] LIM = {4'(HR_MAX), 28'h5959999};

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [31:0]   live, live_nxt, live_inc;
    logic [31:0]   split, split_nxt;
    logic          frozen_nxt, ovf_nxt;
    logic          carry, at_max;
    logic          tick, clear_acc, cap, lap_rel;

    // BCD ripple increment; a carry out of the hours digit means the time is saturated.
    always_comb begin
        live_inc = live;
        carry    = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (carry) begin
                if (live[4*i +: 4] == LIM[4*i +: 4]) begin
                    live_inc[4*i +: 4] = 4'd0;
                end else begin
                    live_inc[4*i +: 4] = live[4*i +: 4] + 4'd1;
                    carry              = 1'b0;
                end
            end
        end
        at_max = carry;
    end

    assign tick      = (state == RUN) && (presc == PRESC_LAST);
    assign clear_acc = Clear && (state != RUN);
    assign cap       = (state == RUN) && Lap;
    assign lap_rel   = Lap && (state != RUN) && !clear_acc && !Start_Stop;

    always_comb begin
        state_nxt  = state;
        presc_nxt  = presc;
        live_nxt   = live;
        split_nxt  = split;
        frozen_nxt = Frozen;
        ovf_nxt    = Overflow;

        if (state == RUN) begin
            presc_nxt = tick ? '0 : presc + PW'(1);
        end
        if (tick) begin
            if (at_max) ovf_nxt  = 1'b1;
            else        live_nxt = live_inc;
        end

        if (clear_acc) begin
            state_nxt  = IDLE;
            presc_nxt  = '0;
            live_nxt   = '0;
            split_nxt  = '0;
            frozen_nxt = 1'b0;
            ovf_nxt    = 1'b0;
        end else begin
            if (Start_Stop) begin
                case (state)
                    IDLE:    state_nxt = RUN;
                    RUN:     state_nxt = PAUSED;
                    PAUSED:  state_nxt = RUN;
                    default: state_nxt = IDLE;
                endcase
            end
            // A split always shows the time as it stands after this edge's tick.
            if (cap) begin
                split_nxt  = live_nxt;
                frozen_nxt = 1'b1;
            end else if (lap_rel) begin
                frozen_nxt = 1'b0;
            end
        end
    end

    always_ff @(negedge NEclk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            presc    <= '0;
            live     <= '0;
            split    <= '0;
            Frozen   <= 1'b0;
            Overflow <= 1'b0;
            Running  <= 1'b0;
            disp     <= '0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            live     <= live_nxt;
            split    <= split_nxt;
            Frozen   <= frozen_nxt;
            Overflow <= ovf_nxt;
            Running  <= (state_nxt == RUN);
            disp     <= frozen_nxt ? split_nxt : live_nxt;
        end
    end

`ifdef STOPWATCH_LAP_FIFO_EN
    localparam int unsigned AW = $clog2(LAP_DEPTH);

    logic [31:0] mem [LAP_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        push, pop;

    assign Lap_empty = (wr_ptr == rd_ptr);
    assign Lap_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = Lap_pop && !Lap_empty;
    assign push      = cap && (!Lap_full || pop);
    assign Lap_data  = Lap_empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(negedge NEclk or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_acc) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: the head is masked to zero while the FIFO is empty.
    always_ff @(negedge NEclk) begin
        if (push && !clear_acc) mem[wr_ptr[AW-1:0]] <= split_nxt;
    end
`endif

endmodule
